// File: rtl/alu_pkg.sv
// Purpose: shared ALU function codes, MIPS opcode/funct constants and the decoded control bundle.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_pkg;

  // 3-bit ALU function select seen by the execute stage
  typedef enum logic [2:0] {
    F_AND = 3'b000,
    F_OR  = 3'b001,
    F_ADD = 3'b010,
    F_SUB = 3'b110,
    F_SLT = 3'b111
  } alu_f_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Decoded controls; use_imm/imm_zext pick the B operand, wr_rt picks rt over rd as destination
  typedef struct packed {
    alu_f_e alu_f;
    logic   regwrite;
    logic   memwrite;
    logic   memtoreg;
    logic   branch;
    logic   use_imm;
    logic   imm_zext;
    logic   wr_rt;
    logic   illegal;
  } ctrl_t;

endpackage

// File: rtl/id_ex_if.sv
// Purpose: bundle of decode-side inputs and execute-side registered outputs of the ID/EX stage.
// Latency: none (wiring only).
// Backpressure: stall holds the stage, flush inserts a bubble; no ready signal back to decode.
// Ports: master = decode/test side (drives instr, valid_in, rd1, rd2, stall, flush);
//        slave  = id_ex_stage (drives alu_a/b/f, controls, writereg, wdata, valid_out, illegal).
interface id_ex_if #(
  parameter int N = 32
);
  logic [31:0]  instr;
  logic         valid_in;
  logic [N-1:0] rd1;
  logic [N-1:0] rd2;
  logic         stall;
  logic         flush;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_f;
  logic         regwrite;
  logic         memwrite;
  logic         memtoreg;
  logic         branch;
  logic [4:0]   writereg;
  logic [N-1:0] wdata;
  logic         valid_out;
  logic         illegal;

  modport master (
    output instr, valid_in, rd1, rd2, stall, flush,
    input  alu_a, alu_b, alu_f, regwrite, memwrite, memtoreg, branch,
           writereg, wdata, valid_out, illegal
  );

  modport slave (
    input  instr, valid_in, rd1, rd2, stall, flush,
    output alu_a, alu_b, alu_f, regwrite, memwrite, memtoreg, branch,
           writereg, wdata, valid_out, illegal
  );
endinterface

// File: rtl/ex_ctrl_dec.sv
// Purpose: combinational opcode/funct decode into ALU function, write/mem/branch controls, imm select, illegal.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage register owns stall/flush.
// Ports: op_i/funct_i instruction fields in; ctrl_o decoded control bundle out.
module ex_ctrl_dec
  import alu_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o       = '0;
    ctrl_o.alu_f = F_ADD;
    case (op_i)
      OP_RTYPE: begin
        ctrl_o.regwrite = 1'b1;
        case (funct_i)
          FN_ADD, FN_ADDU: ctrl_o.alu_f = F_ADD;
          FN_SUB, FN_SUBU: ctrl_o.alu_f = F_SUB;
          FN_AND:          ctrl_o.alu_f = F_AND;
          FN_OR:           ctrl_o.alu_f = F_OR;
          FN_SLT:          ctrl_o.alu_f = F_SLT;
          default: begin
            ctrl_o.regwrite = 1'b0;
            ctrl_o.illegal  = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.use_imm  = 1'b1;
        ctrl_o.wr_rt    = 1'b1;
      end
      OP_SLTI: begin
        ctrl_o.alu_f    = F_SLT;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.use_imm  = 1'b1;
        ctrl_o.wr_rt    = 1'b1;
      end
      OP_ANDI: begin
        ctrl_o.alu_f    = F_AND;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.use_imm  = 1'b1;
        ctrl_o.imm_zext = 1'b1;
        ctrl_o.wr_rt    = 1'b1;
      end
      OP_ORI: begin
        ctrl_o.alu_f    = F_OR;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.use_imm  = 1'b1;
        ctrl_o.imm_zext = 1'b1;
        ctrl_o.wr_rt    = 1'b1;
      end
      OP_LW: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.use_imm  = 1'b1;
        ctrl_o.wr_rt    = 1'b1;
      end
      OP_SW: begin
        ctrl_o.memwrite = 1'b1;
        ctrl_o.use_imm  = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.alu_f  = F_SUB;
        ctrl_o.branch = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Purpose: ID/EX pipeline register with operand muxing and immediate extension around ex_ctrl_dec.
// Latency: 1 cycle from instr/rd1/rd2 to every output.
// Backpressure: stall freezes all outputs; flush (over stall) loads a bubble; reset overrides both.
// Ports: clk, reset (sync, active-high); bus = id_ex_if slave (decode inputs, execute outputs).
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic    clk,
  input  logic    reset,
  id_ex_if.slave  bus
);

  ctrl_t        ctrl;
  logic [N-1:0] imm_sext;
  logic [N-1:0] imm_zext;

  ex_ctrl_dec u_dec (
    .op_i    (bus.instr[31:26]),
    .funct_i (bus.instr[5:0]),
    .ctrl_o  (ctrl)
  );

  // Narrow datapaths simply keep the low N bits of the immediate
  if (N > 16) begin : g_imm_wide
    assign imm_sext = {{(N-16){bus.instr[15]}}, bus.instr[15:0]};
    assign imm_zext = {{(N-16){1'b0}}, bus.instr[15:0]};
  end else if (N == 16) begin : g_imm_exact
    assign imm_sext = bus.instr[15:0];
    assign imm_zext = bus.instr[15:0];
  end else begin : g_imm_narrow
    assign imm_sext = bus.instr[N-1:0];
    assign imm_zext = bus.instr[N-1:0];
  end

  logic [N-1:0] alu_a_d, alu_b_d, wdata_d;
  logic [N-1:0] alu_a_q, alu_b_q, wdata_q;
  alu_f_e       alu_f_d, alu_f_q;
  logic [4:0]   writereg_d, writereg_q;
  logic         regwrite_d, memwrite_d, memtoreg_d, branch_d, valid_d, illegal_d;
  logic         regwrite_q, memwrite_q, memtoreg_q, branch_q, valid_q, illegal_q;

  // Control bits are gated by valid_in so a non-valid slot becomes a clean bubble
  always_comb begin
    alu_a_d    = bus.rd1;
    alu_b_d    = ctrl.use_imm ? (ctrl.imm_zext ? imm_zext : imm_sext) : bus.rd2;
    wdata_d    = bus.rd2;
    writereg_d = ctrl.wr_rt ? bus.instr[20:16] : bus.instr[15:11];
    alu_f_d    = bus.valid_in ? ctrl.alu_f : F_AND;
    regwrite_d = bus.valid_in & ctrl.regwrite;
    memwrite_d = bus.valid_in & ctrl.memwrite;
    memtoreg_d = bus.valid_in & ctrl.memtoreg;
    branch_d   = bus.valid_in & ctrl.branch;
    illegal_d  = bus.valid_in & ctrl.illegal;
    valid_d    = bus.valid_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      wdata_q    <= '0;
      alu_f_q    <= F_AND;
      writereg_q <= '0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      branch_q   <= 1'b0;
      illegal_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else if (bus.flush) begin
      // Operands are don't-care in a bubble, so only the qualifying bits are cleared
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      branch_q   <= 1'b0;
      illegal_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else if (!bus.stall) begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      wdata_q    <= wdata_d;
      alu_f_q    <= alu_f_d;
      writereg_q <= writereg_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      branch_q   <= branch_d;
      illegal_q  <= illegal_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.wdata     = wdata_q;
  assign bus.alu_f     = alu_f_q;
  assign bus.writereg  = writereg_q;
  assign bus.regwrite  = regwrite_q;
  assign bus.memwrite  = memwrite_q;
  assign bus.memtoreg  = memtoreg_q;
  assign bus.branch    = branch_q;
  assign bus.illegal   = illegal_q;
  assign bus.valid_out = valid_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter N, default 32, datapath width of operands delivered to the execute-stage ALU.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports instr input 32 (decoded instruction) and valid_in input 1 (instr/operands meaningful).
REQ-005 SHALL have ports rd1, rd2  input  N  register-file read data for rs, rt.
REQ-006 SHALL have ports stall input 1 (hold stage) and flush input 1 (insert bubble).
REQ-007 SHALL have ports alu_a, alu_b output N (ALU operands) and alu_f output 3 (ALU function code).
REQ-008 SHALL have outputs regwrite, memwrite, memtoreg, branch (1 each), writereg (5), wdata (N, store data), valid_out (1), illegal (1).

Function
REQ-009 SHALL register every output; latency instr/rd1/rd2 -> outputs exactly 1 cycle.
REQ-010 F codes: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
REQ-011 R-type (opcode 000000), funct: 100000/100001 -> ADD, 100010/100011 -> SUB, 100100 -> AND, 100101 -> OR, 101010 -> SLT; alu_a=rd1, alu_b=rd2, regwrite=1, writereg=instr[15:11].
REQ-012 I-type: addi 001000/addiu 001001 -> ADD, slti 001010 -> SLT with sign-extended imm16; andi 001100 -> AND, ori 001101 -> OR with zero-extended imm16; regwrite=1, writereg=instr[20:16], alu_b=extended imm.
REQ-013 lw 100011 -> ADD, alu_b=sign-ext imm, regwrite=1, memtoreg=1, writereg=instr[20:16].
REQ-014 sw 101011 -> ADD, alu_b=sign-ext imm, memwrite=1, wdata=rd2, regwrite=0.
REQ-015 beq 000100 -> SUB, alu_a=rd1, alu_b=rd2, branch=1, regwrite=0.
REQ-016 Sign extension replicates imm16[15] to N bits; zero extension fills with 0; if N<16, low N bits of imm used.
REQ-017 Any other opcode/funct with valid_in=1 SHALL register illegal=1, valid_out=1, alu_f=ADD, all of regwrite/memwrite/memtoreg/branch=0.
REQ-018 valid_in=0 (no flush/stall) SHALL register a bubble: valid_out=0, illegal=0, all control bits 0; operand/F values don't-care.
REQ-019 stall=1 SHALL hold all registered outputs unchanged.
REQ-020 flush=1 SHALL register a bubble regardless of stall or valid_in (flush has priority over stall).
REQ-021 wdata SHALL equal rd2 for every valid instruction, not only sw.

Reset
REQ-022 reset=1 at a clock edge SHALL clear all outputs to 0 (valid_out=0, alu_f=000, illegal=0), overriding stall and flush.
REQ-023 Reset asserted mid-stream SHALL discard the held instruction; first post-reset edge with valid_in=1 loads normally.

Structure
REQ-024 Shared package alu_pkg SHALL hold the 3-bit F code constants/enum and the opcode and funct constants.
REQ-025 Combinational decode SHALL live in one sub-module ex_ctrl_dec (instr -> alu_f, controls, imm select, illegal); id_ex_stage holds the pipeline register and operand muxing.

Verification
REQ-026 add (op 0, funct 100000, rd=3), rd1=5, rd2=7 -> next cycle alu_f=010, alu_a=5, alu_b=7, regwrite=1, writereg=3, valid_out=1.
REQ-027 addi imm=0xFFFF, rd1=10 -> alu_b=0xFFFFFFFF, alu_f=010; ori imm=0xFFFF -> alu_b=0x0000FFFF, alu_f=001.
REQ-028 sw imm=4, rd2=0xDEADBEEF -> memwrite=1, regwrite=0, alu_b=4, wdata=0xDEADBEEF; beq -> alu_f=110, branch=1.
REQ-029 Load slt, then stall=1 for 3 cycles with changing instr -> outputs frozen at slt values (alu_f=111); stall+flush together -> valid_out=0 next cycle.
REQ-030 Opcode 111111, valid_in=1 -> illegal=1, valid_out=1, all write enables 0; next valid add clears illegal.
REQ-031 reset=1 with stall=1 during a held lw -> all outputs 0 after the edge.
